// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and helpers for the pipeline hazard controller.
//   fwd_sel_t   : operand-forwarding mux select (mux3 encoding of execute_stage)
//   mc_state_t  : multi-cycle EX sequencer states
//   reg_hit()   : true when a producer rd matches a consumer rs and is not x0
// ----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_BUSY,
    MC_DONE
  } mc_state_t;

  // x0 is hard-wired to zero, so a write to it never produces a forwardable value.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// ----------------------------------------------------------------------------
// fwd_unit
//   Purely combinational operand-forwarding select for one EX source operand.
//   The younger producer (MEM) has priority over the older one (WB).
// Ports
//   i_rs_e        in  5  source register of the EX instruction
//   i_rd_m        in  5  destination register in MEM
//   i_regwrite_m  in  1  MEM instruction writes the register file
//   i_rd_w        in  5  destination register in WB
//   i_regwrite_w  in  1  WB instruction writes the register file
//   o_sel         out 2  00 reg file, 01 WB result, 10 MEM result
// ----------------------------------------------------------------------------
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs_e,
  input  logic [REG_ADDR_W-1:0] i_rd_m,
  input  logic                  i_regwrite_m,
  input  logic [REG_ADDR_W-1:0] i_rd_w,
  input  logic                  i_regwrite_w,
  output logic [1:0]            o_sel
);

  fwd_sel_t sel;

  // NOTE: every always_comb output gets a default first so no path through the
  // block leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    sel = FWD_REG;
    if (i_regwrite_m && reg_hit(i_rd_m, i_rs_e)) begin
      sel = FWD_MEM;
    end else if (i_regwrite_w && reg_hit(i_rd_w, i_rs_e)) begin
      sel = FWD_WB;
    end
  end

  assign o_sel = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for the 5-stage RISC-V core. All decisions
//   concern the instruction currently in EX:
//     - operand forwarding selects for rs1/rs2
//     - load-use stall of F/D with an ID/EX bubble
//     - branch/jump flush of IF/ID and ID/EX
//     - multi-cycle EX sequencing: F/D/E frozen, MEM fed bubbles, until the
//       iterative unit reports its result (o_mc_done)
//     - saturating count of cycles in which fetch was stalled
// Parameters
//   MC_LATENCY  total cycles a multi-cycle op occupies EX (>= 2)
//   CNT_WIDTH   width of the stall-cycle performance counter
// Ports
//   i_clk, i_rst                      clock, async active-high reset
//   i_rs1_addr_d, i_rs2_addr_d        sources of the DECODE instruction
//   i_rs1_addr_e, i_rs2_addr_e        sources of the EXECUTE instruction
//   i_rd_addr_e, i_resultsrc_e0       EX destination, EX instruction is a load
//   i_pcsrc_e                         branch taken / jump in EX
//   i_mc_start_e                      EX instruction is multi-cycle (level)
//   i_rd_addr_m, i_regwrite_m         MEM producer
//   i_rd_addr_w, i_regwrite_w         WB producer
//   o_forward_a_e, o_forward_b_e      forwarding selects (00 reg, 01 WB, 10 MEM)
//   o_stall_f/d/e                     hold PC, IF/ID, ID/EX
//   o_flush_d/e/m                     clear IF/ID, ID/EX, EX/MEM
//   o_mc_busy, o_mc_done              multi-cycle op holding EX / result valid
//   o_stall_cnt                       saturating count of o_stall_f cycles
// ----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = 34,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_d,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_e,
  input  logic                  i_resultsrc_e0,
  input  logic                  i_pcsrc_e,
  input  logic                  i_mc_start_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_m,
  input  logic                  i_regwrite_m,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_w,
  input  logic                  i_regwrite_w,
  output logic [1:0]            o_forward_a_e,
  output logic [1:0]            o_forward_b_e,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_stall_e,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic                  o_flush_m,
  output logic                  o_mc_busy,
  output logic                  o_mc_done,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

  // Remaining BUSY cycles after the IDLE cycle that accepts the op.
  // The accept cycle plus MC_LATENCY-2 BUSY cycles hold EX for MC_LATENCY-1
  // cycles, and the DONE cycle makes the total occupancy MC_LATENCY.
  localparam int BUSY_CYCLES = MC_LATENCY - 2;
  localparam int MC_CW       = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES + 1) : 1;

  // --------------------------------------------------------------------------
  // Operand forwarding
  // --------------------------------------------------------------------------
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  fwd_unit u_fwd_a (
    .i_rs_e       (i_rs1_addr_e),
    .i_rd_m       (i_rd_addr_m),
    .i_regwrite_m (i_regwrite_m),
    .i_rd_w       (i_rd_addr_w),
    .i_regwrite_w (i_regwrite_w),
    .o_sel        (fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_rs_e       (i_rs2_addr_e),
    .i_rd_m       (i_rd_addr_m),
    .i_regwrite_m (i_regwrite_m),
    .i_rd_w       (i_rd_addr_w),
    .i_regwrite_w (i_regwrite_w),
    .o_sel        (fwd_b)
  );

  // --------------------------------------------------------------------------
  // Load-use detection: the load's data only exists after MEM, so the
  // dependent DECODE instruction must wait one cycle.
  // --------------------------------------------------------------------------
  logic load_use;

  assign load_use = i_resultsrc_e0 &&
                    (reg_hit(i_rd_addr_e, i_rs1_addr_d) ||
                     reg_hit(i_rd_addr_e, i_rs2_addr_d));

  // --------------------------------------------------------------------------
  // Multi-cycle EX sequencer
  // --------------------------------------------------------------------------
  mc_state_t        state_q, state_d;
  logic [MC_CW-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      MC_IDLE: begin
        if (i_mc_start_e) begin
          if (BUSY_CYCLES == 0) begin
            state_d = MC_DONE;
          end else begin
            state_d = MC_BUSY;
            count_d = MC_CW'(BUSY_CYCLES);
          end
        end
      end
      MC_BUSY: begin
        // Branch resolution is deferred while the op holds EX, so i_pcsrc_e
        // has no influence here.
        if (count_q <= MC_CW'(1)) begin
          state_d = MC_DONE;
          count_d = '0;
        end else begin
          count_d = count_q - MC_CW'(1);
        end
      end
      MC_DONE: begin
        // The finished op leaves EX on this edge; a still-high i_mc_start_e
        // belongs to it and must not restart the sequencer.
        state_d = MC_IDLE;
      end
      default: begin
        state_d = MC_IDLE;
        count_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= MC_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // The op is held from the cycle it first appears in EX, before the
  // sequencer has registered it.
  logic mc_hold;

  assign mc_hold = (state_q == MC_BUSY) || ((state_q == MC_IDLE) && i_mc_start_e);

  // --------------------------------------------------------------------------
  // Stall / flush generation. While the mc op holds EX, branch and load-use
  // flushes are suppressed so the held ID/EX contents survive. A load-use
  // stall together with a taken branch still flushes E; fetch takes the
  // redirect regardless of the F/D stall.
  // --------------------------------------------------------------------------
  logic stall_fd;
  logic flush_d;
  logic flush_e;

  assign stall_fd = load_use || mc_hold;
  assign flush_d  = i_pcsrc_e && !mc_hold;
  assign flush_e  = (load_use || i_pcsrc_e) && !mc_hold;

  // Reset forces all controls inactive so the pipeline registers see a
  // quiet interface while the core is held.
  assign o_forward_a_e = i_rst ? 2'b00 : fwd_a;
  assign o_forward_b_e = i_rst ? 2'b00 : fwd_b;
  assign o_stall_f     = stall_fd && !i_rst;
  assign o_stall_d     = stall_fd && !i_rst;
  assign o_stall_e     = mc_hold  && !i_rst;
  assign o_flush_d     = flush_d  && !i_rst;
  assign o_flush_e     = flush_e  && !i_rst;
  assign o_flush_m     = mc_hold  && !i_rst;
  assign o_mc_busy     = mc_hold  && !i_rst;
  assign o_mc_done     = (state_q == MC_DONE) && !i_rst;

  // --------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else if (o_stall_f && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl with MC_LATENCY=4 and CNT_WIDTH=2 so the
//   multi-cycle sequence and counter saturation are reached quickly.
//   Inputs change 1 time unit after a rising edge; outputs are checked 1 time
//   unit later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MC_LATENCY = 4;
  localparam int CNT_WIDTH  = 2;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic [4:0]           i_rs1_addr_d, i_rs2_addr_d;
  logic [4:0]           i_rs1_addr_e, i_rs2_addr_e, i_rd_addr_e;
  logic                 i_resultsrc_e0, i_pcsrc_e, i_mc_start_e;
  logic [4:0]           i_rd_addr_m, i_rd_addr_w;
  logic                 i_regwrite_m, i_regwrite_w;
  logic [1:0]           o_forward_a_e, o_forward_b_e;
  logic                 o_stall_f, o_stall_d, o_stall_e;
  logic                 o_flush_d, o_flush_e, o_flush_m;
  logic                 o_mc_busy, o_mc_done;
  logic [CNT_WIDTH-1:0] o_stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  hazard_ctrl #(
    .MC_LATENCY (MC_LATENCY),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_rs1_addr_d   (i_rs1_addr_d),
    .i_rs2_addr_d   (i_rs2_addr_d),
    .i_rs1_addr_e   (i_rs1_addr_e),
    .i_rs2_addr_e   (i_rs2_addr_e),
    .i_rd_addr_e    (i_rd_addr_e),
    .i_resultsrc_e0 (i_resultsrc_e0),
    .i_pcsrc_e      (i_pcsrc_e),
    .i_mc_start_e   (i_mc_start_e),
    .i_rd_addr_m    (i_rd_addr_m),
    .i_regwrite_m   (i_regwrite_m),
    .i_rd_addr_w    (i_rd_addr_w),
    .i_regwrite_w   (i_regwrite_w),
    .o_forward_a_e  (o_forward_a_e),
    .o_forward_b_e  (o_forward_b_e),
    .o_stall_f      (o_stall_f),
    .o_stall_d      (o_stall_d),
    .o_stall_e      (o_stall_e),
    .o_flush_d      (o_flush_d),
    .o_flush_e      (o_flush_e),
    .o_flush_m      (o_flush_m),
    .o_mc_busy      (o_mc_busy),
    .o_mc_done      (o_mc_done),
    .o_stall_cnt    (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    i_rs1_addr_d   = '0;
    i_rs2_addr_d   = '0;
    i_rs1_addr_e   = '0;
    i_rs2_addr_e   = '0;
    i_rd_addr_e    = '0;
    i_resultsrc_e0 = 1'b0;
    i_pcsrc_e      = 1'b0;
    i_mc_start_e   = 1'b0;
    i_rd_addr_m    = '0;
    i_regwrite_m   = 1'b0;
    i_rd_addr_w    = '0;
    i_regwrite_w   = 1'b0;
  endtask

  // Checks the full stall/flush/mc control vector {f,d,e,fd,fe,fm,busy,done}.
  task automatic check_ctrl(input string tag, input logic [7:0] expected);
    check(tag, {o_stall_f, o_stall_d, o_stall_e, o_flush_d,
                o_flush_e, o_flush_m, o_mc_busy, o_mc_done}, expected);
  endtask

  initial begin
    clear_inputs();
    i_rst = 1'b1;

    // ---- Outputs forced quiet while reset is held ----
    i_regwrite_m = 1'b1; i_rd_addr_m = 5'd5; i_rs1_addr_e = 5'd5;
    i_pcsrc_e = 1'b1; i_mc_start_e = 1'b1;
    settle();
    check("rst_fwd_a", 8'(o_forward_a_e), 8'h00);
    check_ctrl("rst_ctrl", 8'b0000_0000);
    check("rst_cnt", 8'(o_stall_cnt), 8'h0);
    clear_inputs();
    #1 i_rst = 1'b0;
    tick();

    // ---- Forwarding ----
    i_rd_addr_m = 5'd5; i_regwrite_m = 1'b1;
    i_rd_addr_w = 5'd5; i_regwrite_w = 1'b1;
    i_rs1_addr_e = 5'd5;
    settle();
    check("fwd_a_mem_wins", 8'(o_forward_a_e), 8'h2);
    check("fwd_b_x0_src", 8'(o_forward_b_e), 8'h0);
    i_regwrite_m = 1'b0;
    settle();
    check("fwd_a_wb", 8'(o_forward_a_e), 8'h1);
    i_regwrite_m = 1'b1; i_rd_addr_m = 5'd0; i_rd_addr_w = 5'd0; i_rs1_addr_e = 5'd0;
    settle();
    check("fwd_a_x0", 8'(o_forward_a_e), 8'h0);
    i_rd_addr_m = 5'd3; i_rd_addr_w = 5'd4; i_rs1_addr_e = 5'd4; i_rs2_addr_e = 5'd3;
    settle();
    check("fwd_a_split_wb", 8'(o_forward_a_e), 8'h1);
    check("fwd_b_split_mem", 8'(o_forward_b_e), 8'h2);
    check_ctrl("fwd_no_ctrl", 8'b0000_0000);
    clear_inputs();
    tick();
    check("cnt_idle", 8'(o_stall_cnt), 8'h0);

    // ---- Load-use: rd_e=7 matches rs2_d ----
    i_resultsrc_e0 = 1'b1; i_rd_addr_e = 5'd7; i_rs2_addr_d = 5'd7;
    settle();
    check_ctrl("lw_ctrl", 8'b1100_1000);
    tick();
    clear_inputs();
    settle();
    check_ctrl("lw_released", 8'b0000_0000);
    check("lw_cnt", 8'(o_stall_cnt), 8'h1);
    i_resultsrc_e0 = 1'b1; i_rd_addr_e = 5'd0; i_rs1_addr_d = 5'd0;
    settle();
    check_ctrl("lw_x0_no_stall", 8'b0000_0000);
    clear_inputs();
    tick();

    // ---- Taken branch, no load-use ----
    i_pcsrc_e = 1'b1;
    settle();
    check_ctrl("br_flush", 8'b0001_1000);
    tick();
    clear_inputs();
    settle();
    check("br_cnt", 8'(o_stall_cnt), 8'h1);

    // ---- Load-use together with branch: stall F/D, flush D/E ----
    i_resultsrc_e0 = 1'b1; i_rd_addr_e = 5'd7; i_rs1_addr_d = 5'd7; i_pcsrc_e = 1'b1;
    settle();
    check_ctrl("lw_br_ctrl", 8'b1101_1000);
    tick();
    clear_inputs();
    settle();
    check("lw_br_cnt", 8'(o_stall_cnt), 8'h2);

    // ---- Multi-cycle op: held 3 cycles, done on the 4th ----
    i_mc_start_e = 1'b1;
    settle();
    check_ctrl("mc_c0", 8'b1110_0110);
    tick();
    check("mc_c1_cnt", 8'(o_stall_cnt), 8'h3);
    i_pcsrc_e = 1'b1;
    settle();
    check_ctrl("mc_c1_br_ignored", 8'b1110_0110);
    tick();
    i_pcsrc_e = 1'b0;
    settle();
    check_ctrl("mc_c2", 8'b1110_0110);
    check("cnt_saturated", 8'(o_stall_cnt), 8'h3);
    tick();
    check_ctrl("mc_c3_done", 8'b0000_0001);
    tick();
    i_mc_start_e = 1'b0;
    settle();
    check_ctrl("mc_after_done", 8'b0000_0000);
    check("cnt_still_sat", 8'(o_stall_cnt), 8'h3);
    tick();

    // ---- Reset mid-BUSY ----
    i_mc_start_e = 1'b1;
    tick();
    settle();
    check_ctrl("pre_rst_busy", 8'b1110_0110);
    i_rst = 1'b1;
    settle();
    check_ctrl("rst_mid_busy", 8'b0000_0000);
    check("rst_mid_cnt", 8'(o_stall_cnt), 8'h0);
    i_mc_start_e = 1'b0;
    i_rst = 1'b0;
    settle();
    check_ctrl("rst_state_idle", 8'b0000_0000);
    tick();
    check_ctrl("rst_no_done", 8'b0000_0000);

    // Fresh op after reset runs the full sequence from IDLE.
    i_mc_start_e = 1'b1;
    settle();
    check_ctrl("mc2_c0", 8'b1110_0110);
    tick();
    check_ctrl("mc2_c1", 8'b1110_0110);
    tick();
    check_ctrl("mc2_c2", 8'b1110_0110);
    tick();
    check_ctrl("mc2_c3_done", 8'b0000_0001);
    check("mc2_cnt", 8'(o_stall_cnt), 8'h3);
    i_mc_start_e = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
